// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter and sequencer sharing one 4x4 signed Booth multiplier among NREQ requesters.
// Define BOOTH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module booth_mul_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [4*NREQ-1:0]    a_in,
  input  logic [4*NREQ-1:0]    b_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [7:0]           p_out,
  output logic                 busy,
  output logic                 mul_rst_n,
  output logic                 mul_start,
  output logic [3:0]           mul_a,
  output logic [3:0]           mul_b,
  input  logic [7:0]           mul_p
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NU = NREQ;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BUSY,
    CAPTURE,
    GAP
  } state_t;

  state_t          state;
  logic [1:0]      cnt;
  logic [3:0]      op_a;
  logic [3:0]      op_b;
  logic [PW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  logic            found;

`ifdef BOOTH_ARB_FIXED_PRIO_EN
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      if (!found && req[PW'(k)]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
  end
`else
  logic [PW-1:0] ptr;
  int unsigned   idx;

  // Scan starts at ptr and wraps, so the most recent winner has lowest priority next time.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NU) idx = idx - NU;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (state == IDLE && found) begin
      if (win == PW'(NREQ - 1)) ptr <= '0;
      else                      ptr <= win + 1'b1;
    end
  end
`endif

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      done      <= '0;
      p_out     <= '0;
      mul_start <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            op_a      <= a_in[{win, 2'b00} +: 4];
            op_b      <= b_in[{win, 2'b00} +: 4];
            gnt       <= win_oh;
            mul_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (cnt == 2'd3) state <= CAPTURE;
          else             cnt   <= cnt + 2'd1;
        end
        CAPTURE: begin
          p_out <= mul_p;
          done  <= gnt;
          state <= GAP;
        end
        GAP: begin
          gnt   <= '0;
          done  <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mul_rst_n = ~rst;
  assign mul_a     = op_a;
  assign mul_b     = op_b;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural multiplier, vector table, scoreboard of expected completions.
module tb_booth_mul_arbiter;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        p_out, mul_p;
  logic              busy, mul_rst_n, mul_start;
  logic [3:0]        mul_a, mul_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mul_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .p_out(p_out), .busy(busy),
    .mul_rst_n(mul_rst_n), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
  );

  // Multiplier: product on mul_p only in T+5/T+6 after start, from live operands.
  int unsigned       mcnt;
  logic signed [7:0] prod;
  always @(posedge clk) begin
    if (!mul_rst_n)                mcnt <= 0;
    else if (mul_start)            mcnt <= 1;
    else if (mcnt != 0 && mcnt < 7) mcnt <= mcnt + 1;
    else                           mcnt <= 0;
  end
  always_comb begin
    prod  = $signed(mul_a) * $signed(mul_b);
    mul_p = (mcnt == 5 || mcnt == 6) ? prod : 8'hA5;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [7:0]      p;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (sbq.size() == 0) begin
        check("done_unexpected", 32'(done), 32'h0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("done_onehot", 32'(done), 32'(e.oh));
        check("p_out", 32'(p_out), 32'(e.p));
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] mask;
    int              w;
    logic [3:0]      a, b;
    logic [7:0]      p;
    bit              iso;
  } vec_t;
  vec_t vt[7];

  task automatic run_job(input logic [NREQ-1:0] mask, input int w, input logic [3:0] a,
                         input logic [3:0] b, input logic [7:0] p, input bit iso);
    logic [NREQ-1:0] oh;
    bit got;
    oh    = '0;
    oh[w] = 1'b1;
    got   = 1'b0;
    @(posedge clk); #1;
    a_in[4*w +: 4] = a;
    b_in[4*w +: 4] = b;
    req = mask;
    sbq.push_back('{oh: oh, p: p});
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (n == 0) check("busy_idle", 32'(busy), 32'h0);
      if (n == 1) begin
        check("mul_start", 32'(mul_start), 32'h1);
        check("gnt", 32'(gnt), 32'(oh));
        check("mul_a", 32'(mul_a), 32'(a));
        check("mul_b", 32'(mul_b), 32'(b));
        check("busy", 32'(busy), 32'h1);
      end
      if (n == 2 && iso) begin
        a_in[4*w +: 4] = ~a;
        b_in[4*w +: 4] = ~b;
      end
      if (n == 3) check("mul_start_pulse", 32'(mul_start), 32'h0);
      if (done != '0) begin
        got = 1'b1;
        check("latency", 32'(n), 32'd7);
        check("gnt_held", 32'(gnt), 32'(oh));
      end
    end
    check("done_seen", 32'(got), 32'h1);
    req = '0;
  endtask

  initial begin
    int bad;
    int ndone;
    int last_cyc;
    logic [NREQ-1:0] order_mask;

    vt[0] = '{mask: 4'b0001, w: 0, a: 4'd3, b: 4'hE, p: 8'hFA, iso: 1'b0};
    vt[1] = '{mask: 4'b0100, w: 2, a: 4'h8, b: 4'h8, p: 8'h40, iso: 1'b0};
    vt[2] = '{mask: 4'b0100, w: 2, a: 4'h8, b: 4'h7, p: 8'hC8, iso: 1'b0};
    vt[3] = '{mask: 4'b0010, w: 1, a: 4'h7, b: 4'h7, p: 8'h31, iso: 1'b0};
    vt[4] = '{mask: 4'b1000, w: 3, a: 4'hF, b: 4'h5, p: 8'hFB, iso: 1'b0};
    vt[5] = '{mask: 4'b0001, w: 0, a: 4'h0, b: 4'h8, p: 8'h00, iso: 1'b0};
    vt[6] = '{mask: 4'b0010, w: 1, a: 4'h5, b: 4'h3, p: 8'h0F, iso: 1'b1};

    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_p_out", 32'(p_out), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mul_start", 32'(mul_start), 32'h0);
    check("rst_mul_a", 32'(mul_a), 32'h0);
    check("rst_mul_b", 32'(mul_b), 32'h0);
    check("rst_mul_rst_n", 32'(mul_rst_n), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_job(vt[i].mask, vt[i].w, vt[i].a, vt[i].b, vt[i].p, vt[i].iso);

    // No requests: nothing moves, product holds.
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (mul_start || busy || gnt != '0 || done != '0) bad++;
    end
    check("idle_hold", 32'(bad), 32'h0);
    check("p_out_hold", 32'(p_out), 32'h0F);

    // Reset in the middle of a job on requester 2.
    @(posedge clk); #1;
    a_in[8 +: 4] = 4'h3;
    b_in[8 +: 4] = 4'h3;
    req = 4'b0100;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 3) rst = 1'b1;
    end
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    check("abort_mul_rst_n", 32'(mul_rst_n), 32'h0);
    rst = 1'b0;
    req = '0;
    run_job(4'b1001, 0, 4'hE, 4'hD, 8'h06, 1'b0);
    run_job(4'b1000, 3, 4'h4, 4'hC, 8'hF0, 1'b0);

    // Contention from reset: 1111 for five jobs, then 0110 for three.
    @(posedge clk); #1;
    rst  = 1'b1;
    a_in = {4'h4, 4'h3, 4'h2, 4'h1};
    b_in = {4'hC, 4'hD, 4'hE, 4'hF};
    req  = 4'b1111;
`ifdef BOOTH_ARB_FIXED_PRIO_EN
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0010, p: 8'hFC});
    sbq.push_back('{oh: 4'b0010, p: 8'hFC});
    sbq.push_back('{oh: 4'b0010, p: 8'hFC});
`else
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0010, p: 8'hFC});
    sbq.push_back('{oh: 4'b0100, p: 8'hF7});
    sbq.push_back('{oh: 4'b1000, p: 8'hF0});
    sbq.push_back('{oh: 4'b0001, p: 8'hFF});
    sbq.push_back('{oh: 4'b0010, p: 8'hFC});
    sbq.push_back('{oh: 4'b0100, p: 8'hF7});
    sbq.push_back('{oh: 4'b0010, p: 8'hFC});
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone    = 0;
    last_cyc = 0;
    for (int n = 0; n < 120 && ndone < 8; n++) begin
      @(negedge clk);
      if (done != '0) begin
        if (ndone > 0) check("job_period", 32'(cyc - last_cyc), 32'd8);
        last_cyc = cyc;
        ndone++;
        if (ndone == 5) req = 4'b0110;
        if (ndone == 8) req = '0;
      end
    end
    check("contention_jobs", 32'(ndone), 32'd8);

    repeat (12) @(negedge clk);
    order_mask = gnt;
    check("final_gnt", 32'(order_mask), 32'h0);
    check("sb_drain", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one 4-bit signed Booth multiplier among NREQ requesters. It grants one requester at a time and latches that requester's operands. It drives the multiplier's start/operand/reset pins, captures the 8-bit product at a fixed cycle, and returns it with a one-cycle done pulse. It sits between the requesting datapath blocks and the single multiplier instance.

## Interface
- NREQ, default 4: number of requesters, legal range 2..8.
- clk  in  1: single clock; all state updates on rising edge.
- rst  in  1: synchronous reset, active-high.
- req  in  NREQ: level request, bit i = requester i.
- a_in  in  4*NREQ: signed multiplicand; requester i at [4i+3:4i].
- b_in  in  4*NREQ: signed multiplier; requester i at [4i+3:4i].
- gnt  out  NREQ: one-hot grant, registered.
- done  out  NREQ: one-hot, one-cycle completion pulse, registered.
- p_out  out  8: signed product. Valid in the done cycle; held until the next capture.
- busy  out  1: high whenever state is not IDLE.
- mul_rst_n  out  1: multiplier reset, equal to ~rst (active-low, synchronous at the multiplier).
- mul_start  out  1: one-cycle start pulse to the multiplier.
- mul_a, mul_b  out  4 each: operands to the multiplier, driven from latched registers.
- mul_p  in  8: multiplier product.

## Operation
- Multiplier contract:
  - Start sampled in cycle T.
  - Product valid on mul_p in cycles T+5 and T+6.
  - Multiplier idle again (ready to accept start) from T+7.
  - Operands must be stable from T through T+6.
- FSM states: IDLE, START, BUSY, CAPTURE, GAP.
  - IDLE: if req != 0, select winner W. Latch a_in[W]/b_in[W] into op_a/op_b, latch W, set gnt = onehot(W), go START. Else stay in IDLE.
  - START: mul_start = 1, clear cycle counter, go BUSY.
  - BUSY: 4 cycles (counter 0..3). Go CAPTURE after counter 3.
  - CAPTURE: p_out <= mul_p, done <= onehot(W), go GAP.
  - GAP: done visible this cycle. Clear gnt and done at the end of the cycle, go IDLE.
- mul_a/mul_b = op_a/op_b in all states. They change only on the IDLE→START transition.
- Round-robin rule:
  - Pointer ptr (0..NREQ-1) marks the highest-priority index.
  - The winner is the first set req bit scanning ptr, ptr+1, … with wrap-around at NREQ-1→0.
  - On grant, ptr <= W+1 mod NREQ.
- Requester handshake:
  - Requester holds req high and its operands stable until it sees its done bit.
  - It then drops req in the following cycle unless it wants another job.
  - req is sampled only in IDLE. Changes in other states are ignored.
- A requester that keeps req high after done re-enters arbitration at ptr priority. No starvation: every active requester is served within NREQ jobs.
- Arithmetic: 4×4 signed → 8-bit signed, passed through unmodified. The full range −8×−8 = +64 and −8×7 = −56 fits.

## Timing
- Reset values: state IDLE, ptr 0, gnt 0, done 0, p_out 0, busy 0, mul_start 0, mul_a 0, mul_b 0. mul_rst_n is low during rst.
- Per-job schedule, with req seen in IDLE at cycle R:
  - gnt high in R+1..R+7.
  - mul_start high in R+1.
  - Capture at end of R+6.
  - done high in R+7.
  - IDLE again at R+8.
- Latency req→done is 7 cycles. Back-to-back job period is 8 cycles.
- Simultaneous requests: exactly one grant per IDLE decision. Others wait.
- rst mid-job: on the next edge everything returns to reset values and the multiplier is reset through mul_rst_n. No done is issued for the aborted job, and ptr returns to 0.
- req all zero in IDLE: stay idle; all outputs hold and mul_start stays 0.

## Configuration
- BOOTH_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest set req index wins. ptr is not implemented.
  - Undefined (default): round-robin as above.
  - The FSM and timing are identical in both cases.

## Test plan
- Single request: req = 0001, a0 = 3, b0 = −2 at R → mul_start at R+1, done = 0001 at R+7, p_out = 8'hFA (−6).
- Extremes: requester 2 with a = −8, b = −8 → p_out = 8'h40. Then a = −8, b = 7 → p_out = 8'hC8.
- Contention, round-robin: req = 1111 held continuously from reset → grant order 0,1,2,3,0. done pulses every 8 cycles.
- Contention, BOOTH_ARB_FIXED_PRIO_EN defined: req = 0110 held → requester 1 served every job, requester 2 never.
- Reset mid-job: assert rst at R+3 for one cycle → no done pulse, gnt = 0 and busy = 0 at R+4. A new req = 1000 afterwards completes normally, granted because ptr = 0 scanning reaches 3.
- Operand isolation: change a_in/b_in of the granted requester at R+2 → p_out reflects the operands latched at R.
